// File: rtl/uart_tx_pulse.sv
// uart_tx_pulse
//   Single-byte UART transmitter started by a one-cycle send pulse.
//   Frame: start (0), 8 data bits LSB first, optional parity, stop (1).
//   The next frame may be requested in the cycle done is high.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   PARITY       : 0 none, 1 even, 2 odd
//
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   send  : one-cycle request; data is sampled when it is accepted
//   data  : byte to transmit
//   tx    : serial line, idle high, registered
//   busy  : high while a frame is in progress
//   done  : one-cycle pulse in the first idle cycle after the stop bit
module uart_tx_pulse #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic        PAR_EN  = (PARITY != 0);
  localparam logic        PAR_ODD = (PARITY == 2);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic        par, par_n;
  logic        tx_q, tx_n;
  logic        done_q, done_n;
  logic        bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      par    <= par_n;
      tx_q   <= tx_n;
      done_q <= done_n;
    end
  end

  // tx is registered, so the next-state logic also computes the value the
  // line must carry during the next bit; it changes exactly on the edge
  // where the bit boundary is taken.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    tx_n    = tx_q;
    done_n  = 1'b0;
    bit_end = (cnt == '0);

    if (state != S_IDLE && !bit_end) begin
      cnt_n = cnt - 16'd1;
    end

    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (send) begin
          sh_n    = data;
          par_n   = (^data) ^ PAR_ODD;
          cnt_n   = RELOAD;
          idx_n   = '0;
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          cnt_n   = RELOAD;
          tx_n    = sh[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n = RELOAD;
          if (idx == 3'd7) begin
            if (PAR_EN) begin
              state_n = S_PARITY;
              tx_n    = par;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            // bit 0 of the shift register is the bit on the line; the
            // next one is looked ahead at sh[1] as the register shifts.
            idx_n = idx + 3'd1;
            sh_n  = {1'b0, sh[7:1]};
            tx_n  = sh[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          cnt_n   = RELOAD;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_pulse.sv
module tb_uart_tx_pulse;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] send_v;
  logic [7:0] data;
  logic [2:0] tx_v, busy_v, done_v;

  int applied;
  int miscompares;

  uart_tx_pulse #(.CLKS_PER_BIT(C), .PARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .send(send_v[0]), .data(data),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_pulse #(.CLKS_PER_BIT(C), .PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .send(send_v[1]), .data(data),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_pulse #(.CLKS_PER_BIT(C), .PARITY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .send(send_v[2]), .data(data),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bits[i] is the expected line level during frame bit i (0 = start)
  typedef struct {
    int          mode;
    logic [7:0]  d;
    logic [10:0] bits;
    int          nb;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic got, input logic exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  // presend: caller already raised send/data at the current negedge.
  // inject_at: frame cycle at which a second send is pulsed (-1 none).
  // chain: raise send with next_d in the done cycle.
  task automatic frame(input int m, input logic [7:0] d, input logic [10:0] bits,
                       input int nb, input int inject_at, input bit presend,
                       input bit chain, input logic [7:0] next_d);
    if (!presend) begin
      @(negedge clk);
      send_v[m] = 1'b1;
      data      = d;
    end
    @(negedge clk);
    send_v[m] = 1'b0;
    data      = ~d;
    for (int j = 0; j < nb * C; j++) begin
      chk($sformatf("m%0d d%02h tx j%0d", m, d, j), tx_v[m], bits[j / C]);
      chk($sformatf("m%0d d%02h busy j%0d", m, d, j), busy_v[m], 1'b1);
      chk($sformatf("m%0d d%02h done j%0d", m, d, j), done_v[m], 1'b0);
      send_v[m] = (j == inject_at);
      data      = 8'($urandom);
      @(negedge clk);
    end
    send_v[m] = 1'b0;
    chk($sformatf("m%0d d%02h done_end", m, d), done_v[m], 1'b1);
    chk($sformatf("m%0d d%02h busy_end", m, d), busy_v[m], 1'b0);
    chk($sformatf("m%0d d%02h tx_end", m, d), tx_v[m], 1'b1);
    if (chain) begin
      send_v[m] = 1'b1;
      data      = next_d;
    end else begin
      @(negedge clk);
      chk($sformatf("m%0d d%02h done_after", m, d), done_v[m], 1'b0);
      chk($sformatf("m%0d d%02h tx_after", m, d), tx_v[m], 1'b1);
    end
  endtask

  initial begin
    bit bad_tx, bad_busy, bad_done;
    applied     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    send_v      = '0;
    data        = '0;

    //            mode  data    parity/stop     nbits
    vt[0] = '{0, 8'hA5, 11'b0_1_10100101_0, 10};
    vt[1] = '{1, 8'h07, 11'b1_1_00000111_0, 11};
    vt[2] = '{2, 8'h07, 11'b1_0_00000111_0, 11};
    vt[3] = '{0, 8'h00, 11'b0_1_00000000_0, 10};
    vt[4] = '{0, 8'hFF, 11'b0_1_11111111_0, 10};
    vt[5] = '{1, 8'h00, 11'b1_0_00000000_0, 11};
    vt[6] = '{2, 8'h00, 11'b1_1_00000000_0, 11};
    vt[7] = '{1, 8'hFF, 11'b1_0_11111111_0, 11};
    vt[8] = '{2, 8'h81, 11'b1_1_10000001_0, 11};
    vt[9] = '{0, 8'h55, 11'b0_1_01010101_0, 10};

    // reset state
    #12;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst m%0d tx", m), tx_v[m], 1'b1);
      chk($sformatf("rst m%0d busy", m), busy_v[m], 1'b0);
      chk($sformatf("rst m%0d done", m), done_v[m], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // idle with data toggling and no send
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 1000; i++) begin
      data = 8'($urandom);
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        if (tx_v[m] !== 1'b1)   bad_tx = 1;
        if (busy_v[m] !== 1'b0) bad_busy = 1;
        if (done_v[m] !== 1'b0) bad_done = 1;
      end
    end
    chk("idle tx stays high", bad_tx, 1'b0);
    chk("idle busy stays low", bad_busy, 1'b0);
    chk("idle done never", bad_done, 1'b0);

    // table-driven frames
    for (int v = 0; v < 10; v++)
      frame(vt[v].mode, vt[v].d, vt[v].bits, vt[v].nb, -1, 1'b0, 1'b0, 8'h00);

    // second send mid-frame is ignored and leaves no queued frame
    frame(0, 8'hA5, vt[0].bits, 10, 11, 1'b0, 1'b0, 8'h00);
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1)   bad_tx = 1;
      if (busy_v[0] !== 1'b0) bad_busy = 1;
    end
    chk("ignored send tx idle", bad_tx, 1'b0);
    chk("ignored send busy idle", bad_busy, 1'b0);

    // back-to-back: send in the done cycle
    frame(0, 8'hA5, vt[0].bits, 10, -1, 1'b0, 1'b1, 8'h3C);
    frame(0, 8'h3C, 11'b0_1_00111100_0, 10, -1, 1'b1, 1'b0, 8'h00);

    // reset during data bit 3 (frame bit 4, tx = 0 for 8'hA5)
    @(negedge clk);
    send_v[0] = 1'b1;
    data      = 8'hA5;
    @(negedge clk);
    send_v[0] = 1'b0;
    for (int j = 0; j < 4 * C + 1; j++) @(negedge clk);
    chk("pre-reset tx bit3", tx_v[0], 1'b0);
    chk("pre-reset busy", busy_v[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-frame rst tx", tx_v[0], 1'b1);
    chk("mid-frame rst busy", busy_v[0], 1'b0);
    chk("mid-frame rst done", done_v[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset tx", tx_v[0], 1'b1);
    chk("post-reset busy", busy_v[0], 1'b0);
    frame(0, 8'h55, vt[9].bits, 10, -1, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_pulse.md
UART_TX_PULSE -- requirements
Module: uart_tx_pulse

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the clock cycles per bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 even, 2 odd.
REQ-003 Port clk  input  1  SHALL be the single system clock (100 MHz); all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port send  input  1  SHALL be the one-cycle send request, the single-cycle pulse produced by the team's button debouncer.
REQ-006 Port data  input  8  SHALL be the byte to transmit, sampled in the cycle send is accepted.
REQ-007 Port tx  output  1  SHALL be the serial line, idle high, driven from a register.
REQ-008 Port busy  output  1  SHALL be high whenever a frame is in progress.
REQ-009 Port done  output  1  SHALL be a one-cycle pulse marking the end of a frame.

Function
REQ-010 Frame format SHALL be: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-012 The PARITY state SHALL be skipped when PARITY=0.
REQ-013 In IDLE with send=1 at rising edge k, the block SHALL latch data into a shift register and enter START.
REQ-014 After edge k: tx=0 and busy=1 (one-cycle latency from the send edge).
REQ-015 Each bit SHALL hold tx stable for exactly CLKS_PER_BIT cycles, timed by a down-counter or up-counter that reloads at each bit boundary.
REQ-016 Bit i (i = 0 start, 1..8 data, 9 parity if enabled, last = stop) SHALL begin at edge k + i*CLKS_PER_BIT.
REQ-017 A 3-bit index SHALL count data bits 0..7; the move from DATA to PARITY or STOP SHALL occur after index 7 completes.
REQ-018 The parity bit SHALL be the XOR of the latched 8 bits (even), or its inverse (odd).
REQ-019 At edge k + F*CLKS_PER_BIT (F=10 without parity, 11 with parity) the FSM SHALL return to IDLE, with done=1 for exactly that one cycle, busy=0 and tx=1.
REQ-020 send while busy=1 SHALL be ignored entirely: no queueing, no change to the frame in flight.
REQ-021 send in the cycle done=1 SHALL be accepted, giving back-to-back frames with no idle gap beyond one stop-bit length.
REQ-022 Changes on data after acceptance SHALL NOT affect the frame in flight.
REQ-023 The counter width SHALL be 16 bits; no wrap-around SHALL occur within the legal CLKS_PER_BIT range.
REQ-024 busy SHALL be derived from state != IDLE and registered-equivalent (no combinational path from send to busy).

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, tx=1, busy=0, done=0, and counter, index and shift register cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with tx=1 in the same cycle.
REQ-027 After rst_n deasserts, the first send SHALL be accepted as in REQ-013.

Verification (CLKS_PER_BIT=4 for simulation)
REQ-028 Scenario: PARITY=0, send pulse with data=8'hA5 -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done high at cycle 40 after the send edge; busy high in cycles 1..39.
REQ-029 Scenario: PARITY=1, data=8'h07 -> parity bit 1; PARITY=2, data=8'h07 -> parity bit 0; frame length 44 cycles.
REQ-030 Scenario: second send at cycle 12 of a frame with a different data value -> first frame unchanged, no second frame follows.
REQ-031 Scenario: send asserted in the done cycle with data=8'h3C -> the next start bit begins on the following edge; frames contiguous.
REQ-032 Scenario: rst_n pulsed low during data bit 3 -> tx=1, busy=0, done=0 at once; a later send of 8'h55 transmits correctly.
REQ-033 Scenario: send held low and data toggling for 1000 cycles after reset -> tx stays 1, busy stays 0, done never pulses.
